saradc_sar_ctrl: RTL and testbench

SAR sequencer that drives the switch-control inputs of an NBITS-wide array of CDAC units, one unit per bit, MSB = bit NBITS-1. It sits directly upstream of the CDAC array and handles the full conversion:
- sample phase;
- binary-search trials under control of an external comparator;
- break-before-make sequencing of every switch transition;
- delivery of the converted code.

All switch controls are registered and emitted as complementary pairs that feed the CDAC units' CRI/CRIB, CRH/CRHB and CRL/CRLB pins.

---
 rtl/saradc_sar_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_saradc_sar_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/saradc_sar_ctrl.sv
// saradc_sar_ctrl
// ---------------
// SAR conversion sequencer driving an NBITS-wide CDAC switch array, one unit
// per bit (MSB = bit NBITS-1). Runs sample phase, binary-search trials against
// an external comparator, break-before-make switch sequencing and code output.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   START             conversion request, sampled only in IDLE
//   CMP               comparator result, 1 keeps the bit under trial
//   CRI/CRIB          input-to-cap switch enables and their exact complement
//   CRH/CRHB          cap-to-VOUTH switch enables and complement
//   CRL/CRLB          cap-to-VOUTL switch enables and complement
//   COMP_EN           comparator strobe, one cycle per bit
//   DOUT              converted code, held until the next conversion starts
//   VALID             one-cycle pulse when DOUT is new
//   BUSY              high in every state except IDLE
//   DBG_STATE         current FSM state encoding
//
// Handshake: START is a level request with no ready; it is taken only when
// the FSM is in IDLE and ignored otherwise, so holding it high chains
// conversions with exactly one IDLE cycle between them. CMP has no valid;
// it must be settled by the end of the EVAL cycle (two cycles after the
// COMP_EN rising edge), the only cycle in which it is sampled.

module saradc_sar_ctrl #(
  parameter int NBITS   = 8,
  parameter int NSAMP   = 4,
  parameter int NOVL    = 1,
  parameter int NSETTLE = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CMP,
  output logic [NBITS-1:0] CRI,
  output logic [NBITS-1:0] CRIB,
  output logic [NBITS-1:0] CRH,
  output logic [NBITS-1:0] CRHB,
  output logic [NBITS-1:0] CRL,
  output logic [NBITS-1:0] CRLB,
  output logic             COMP_EN,
  output logic [NBITS-1:0] DOUT,
  output logic             VALID,
  output logic             BUSY,
  output logic [2:0]       DBG_STATE
);

  localparam int KW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int MAXA = (NSAMP > NOVL) ? NSAMP : NOVL;
  localparam int MAXP = (MAXA > NSETTLE) ? MAXA : NSETTLE;
  localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [PW-1:0] SAMP_LAST   = PW'(NSAMP - 1);
  localparam logic [PW-1:0] OVL_LAST    = PW'(NOVL - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(NSETTLE - 1);
  localparam logic [KW-1:0] K_TOP       = KW'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMP   = 3'd1,
    S_GAP    = 3'd2,
    S_SETTLE = 3'd3,
    S_STROBE = 3'd4,
    S_EVAL   = 3'd5,
    S_BREAK  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_cnt;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    w_k_nxt;
  logic [NBITS-1:0] r_dout;
  logic [NBITS-1:0] w_dout_nxt;

  logic [NBITS-1:0] w_cri_nxt;
  logic [NBITS-1:0] w_crh_nxt;
  logic [NBITS-1:0] w_crl_nxt;

  logic [NBITS-1:0] r_cri, r_crib, r_crh, r_crhb, r_crl, r_crlb;
  logic             r_comp_en, r_valid, r_busy;

  // State register: FSM state, phase counter, bit index and result code.
  // The phase counter restarts on every state change, so each timed state
  // simply waits for its own terminal count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_dout  <= w_dout_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + PW'(1);
    end
  end

  // Next-state logic, including the bit index and the code being built.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_dout_nxt  = r_dout;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_SAMP;
          w_dout_nxt  = '0;
        end
      end
      S_SAMP:   if (r_cnt == SAMP_LAST) w_state_nxt = S_GAP;
      S_GAP: begin
        if (r_cnt == OVL_LAST) begin
          w_state_nxt = S_SETTLE;
          w_k_nxt     = K_TOP;
        end
      end
      S_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_EVAL;
      S_EVAL: begin
        w_dout_nxt[r_k] = CMP;
        w_state_nxt     = (r_k == '0) ? S_DONE : S_BREAK;
      end
      S_BREAK: begin
        if (r_cnt == OVL_LAST) begin
          w_state_nxt = S_SETTLE;
          w_k_nxt     = r_k - KW'(1);
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: switch pattern for the state being entered, so every
  // output comes straight from a register. In BREAK the index still names
  // the bit just decided; cap k-1 is parked OFF before it goes L->H, and
  // cap k is parked OFF only when it is about to go H->L.
  always_comb begin
    w_cri_nxt = '0;
    w_crh_nxt = '0;
    w_crl_nxt = '0;
    case (w_state_nxt)
      S_SAMP: w_cri_nxt = '1;
      S_SETTLE, S_STROBE, S_EVAL, S_BREAK: begin
        for (int j = 0; j < NBITS; j++) begin
          if (j > int'(w_k_nxt)) begin
            w_crh_nxt[j] = w_dout_nxt[j];
            w_crl_nxt[j] = ~w_dout_nxt[j];
          end else if (j == int'(w_k_nxt)) begin
            w_crh_nxt[j] = (w_state_nxt == S_BREAK) ? w_dout_nxt[j] : 1'b1;
          end else if (w_state_nxt != S_BREAK || j != int'(w_k_nxt) - 1) begin
            w_crl_nxt[j] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers. Complements are registered separately from the true
  // outputs so each pair is exact in every cycle, including reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cri     <= '0;
      r_crib    <= '1;
      r_crh     <= '0;
      r_crhb    <= '1;
      r_crl     <= '0;
      r_crlb    <= '1;
      r_comp_en <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_cri     <= w_cri_nxt;
      r_crib    <= ~w_cri_nxt;
      r_crh     <= w_crh_nxt;
      r_crhb    <= ~w_crh_nxt;
      r_crl     <= w_crl_nxt;
      r_crlb    <= ~w_crl_nxt;
      r_comp_en <= (w_state_nxt == S_STROBE);
      r_valid   <= (w_state_nxt == S_DONE);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign CRI       = r_cri;
  assign CRIB      = r_crib;
  assign CRH       = r_crh;
  assign CRHB      = r_crhb;
  assign CRL       = r_crl;
  assign CRLB      = r_crlb;
  assign COMP_EN   = r_comp_en;
  assign DOUT      = r_dout;
  assign VALID     = r_valid;
  assign BUSY      = r_busy;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Testbench for saradc_sar_ctrl: default instance (8 bits) plus a small
// instance (NBITS=4, NSAMP=1, NOVL=2, NSETTLE=1). Expected codes and VALID
// cycles are queued when START is driven and retired when VALID is due.

module tb_saradc_sar_ctrl;

  localparam int NB   = 8, NS  = 4, NO  = 1, NST  = 2;
  localparam int NB4  = 4, NS4 = 1, NO4 = 2, NST4 = 1;
  localparam int LAT  = 1 + NS  + NO  + NB  * (NST  + 2) + (NB  - 1) * NO;   // 45
  localparam int LAT4 = 1 + NS4 + NO4 + NB4 * (NST4 + 2) + (NB4 - 1) * NO4;  // 22
  localparam int PER  = LAT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start = 1'b0, cmp = 1'b0, start4 = 1'b0, cmp4 = 1'b0;
  logic [NB-1:0]  cri, crib, crh, crhb, crl, crlb, dout;
  logic [NB4-1:0] cri4, crib4, crh4, crhb4, crl4, crlb4, dout4;
  logic comp_en, valid, busy, comp_en4, valid4, busy4;
  logic [2:0] dbg_state, dbg_state4;

  saradc_sar_ctrl #(.NBITS(NB), .NSAMP(NS), .NOVL(NO), .NSETTLE(NST)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .CMP(cmp),
    .CRI(cri), .CRIB(crib), .CRH(crh), .CRHB(crhb), .CRL(crl), .CRLB(crlb),
    .COMP_EN(comp_en), .DOUT(dout), .VALID(valid), .BUSY(busy),
    .DBG_STATE(dbg_state)
  );

  saradc_sar_ctrl #(.NBITS(NB4), .NSAMP(NS4), .NOVL(NO4), .NSETTLE(NST4)) u_dut4 (
    .CLK(clk), .RST(rst), .START(start4), .CMP(cmp4),
    .CRI(cri4), .CRIB(crib4), .CRH(crh4), .CRHB(crhb4), .CRL(crl4), .CRLB(crlb4),
    .COMP_EN(comp_en4), .DOUT(dout4), .VALID(valid4), .BUSY(busy4),
    .DBG_STATE(dbg_state4)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / models ----------------
  logic [NB-1:0]  exp_q[$];
  int             exp_t_q[$];
  logic [NB4-1:0] exp4_q[$];
  int             exp4_t_q[$];

  logic [NB-1:0]  code  = '0;
  logic [NB4-1:0] code4 = '0;
  int sidx = 0, sidx4 = 0;
  bit mon_on = 1'b0;

  int last_on[2][NB];
  int off_cnt[2][NB];

  // Per-cap rules: exact complements, one-hot-or-zero, and every change
  // between two different on-states within a conversion goes through
  // exactly novl OFF cycles.
  task automatic mon_caps(input int id, input int nb, input int novl,
                          input logic [NB-1:0] it, ib, ht, hb, lt, lb, input logic bsy);
    int compl_v, oh_v, gap_v, cur;
    compl_v = 0; oh_v = 0; gap_v = 0;
    for (int j = 0; j < nb; j++) begin
      if (ib[j] !== ~it[j] || hb[j] !== ~ht[j] || lb[j] !== ~lt[j]) compl_v++;
      if (int'(it[j]) + int'(ht[j]) + int'(lt[j]) > 1) oh_v++;
      cur = it[j] ? 1 : ht[j] ? 2 : lt[j] ? 3 : 0;
      if (!bsy) begin
        last_on[id][j] = 0;
        off_cnt[id][j] = 0;
      end else if (cur == 0) begin
        off_cnt[id][j]++;
      end else begin
        if (last_on[id][j] != 0 && cur != last_on[id][j] && off_cnt[id][j] != novl) gap_v++;
        last_on[id][j] = cur;
        off_cnt[id][j] = 0;
      end
    end
    check_eq($sformatf("complement_u%0d", id), compl_v, 0);
    check_eq($sformatf("onehot_u%0d", id), oh_v, 0);
    check_eq($sformatf("bbm_gap_u%0d", id), gap_v, 0);
  endtask

  // Switch pattern while bit k is under trial.
  task automatic check_strobe(input int id, input int nb, input logic [NB-1:0] c, input int k,
                              input logic [NB-1:0] it, ht, lt);
    logic [NB-1:0] eh, el;
    eh = '0; el = '0;
    for (int j = 0; j < nb; j++) begin
      eh[j] = (j > k) ? c[j] : (j == k);
      el[j] = ~eh[j];
    end
    check_eq($sformatf("strobe_crh_u%0d_k%0d", id, k), 32'(ht), 32'(eh));
    check_eq($sformatf("strobe_crl_u%0d_k%0d", id, k), 32'(lt), 32'(el));
    check_eq($sformatf("strobe_cri_u%0d_k%0d", id, k), 32'(it), 0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      logic eb;
      mon_caps(0, NB, NO, cri, crib, crh, crhb, crl, crlb, busy);
      eb = 1'b0;
      if (exp_t_q.size() > 0) eb = (cyc >= exp_t_q[0] - (LAT - 1)) && (cyc <= exp_t_q[0]);
      check_eq("busy_u0", 32'(busy), 32'(eb));
      if (!busy) sidx = 0;
      if (comp_en) begin
        if (sidx < NB) begin
          check_strobe(0, NB, code, NB - 1 - sidx, cri, crh, crl);
          cmp = code[NB - 1 - sidx];
        end
        sidx++;
      end
      if (exp_t_q.size() > 0 && cyc == exp_t_q[0]) begin
        check_eq("valid_u0", 32'(valid), 1);
        check_eq("dout_u0", 32'(dout), 32'(exp_q[0]));
        check_eq("strobes_u0", sidx, NB);
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
      end else begin
        check_eq("valid_idle_u0", 32'(valid), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      logic eb;
      mon_caps(1, NB4, NO4, NB'(cri4), NB'(crib4), NB'(crh4), NB'(crhb4),
               NB'(crl4), NB'(crlb4), busy4);
      eb = 1'b0;
      if (exp4_t_q.size() > 0) eb = (cyc >= exp4_t_q[0] - (LAT4 - 1)) && (cyc <= exp4_t_q[0]);
      check_eq("busy_u1", 32'(busy4), 32'(eb));
      if (!busy4) sidx4 = 0;
      if (comp_en4) begin
        if (sidx4 < NB4) begin
          check_strobe(1, NB4, NB'(code4), NB4 - 1 - sidx4, NB'(cri4), NB'(crh4), NB'(crl4));
          cmp4 = code4[NB4 - 1 - sidx4];
        end
        sidx4++;
      end
      if (exp4_t_q.size() > 0 && cyc == exp4_t_q[0]) begin
        check_eq("valid_u1", 32'(valid4), 1);
        check_eq("dout_u1", 32'(dout4), 32'(exp4_q[0]));
        check_eq("strobes_u1", sidx4, NB4);
        void'(exp4_q.pop_front());
        void'(exp4_t_q.pop_front());
      end else begin
        check_eq("valid_idle_u1", 32'(valid4), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; START is sampled at the next edge, so
  // the current cycle number is t.
  task automatic launch(input logic [NB-1:0] c);
    code  = c;
    start = 1'b1;
    exp_q.push_back(c);
    exp_t_q.push_back(cyc + LAT);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic launch4(input logic [NB4-1:0] c);
    code4  = c;
    start4 = 1'b1;
    exp4_q.push_back(c);
    exp4_t_q.push_back(cyc + LAT4);
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_t_q.size() > 0 || exp4_t_q.size() > 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_timeout", exp_t_q.size() + exp4_t_q.size(), 0);
  endtask

  task automatic check_reset_state();
    check_eq("rst_cri",  32'(cri),  0);
    check_eq("rst_crib", 32'(crib), 32'({NB{1'b1}}));
    check_eq("rst_crh",  32'(crh),  0);
    check_eq("rst_crhb", 32'(crhb), 32'({NB{1'b1}}));
    check_eq("rst_crl",  32'(crl),  0);
    check_eq("rst_crlb", 32'(crlb), 32'({NB{1'b1}}));
    check_eq("rst_comp_en", 32'(comp_en), 0);
    check_eq("rst_dout",  32'(dout),  0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_busy",  32'(busy),  0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NB-1:0] rc;
    int t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    check_eq("rst_crib_u1", 32'(crib4), 32'({NB4{1'b1}}));
    check_eq("rst_busy_u1", 32'(busy4), 0);
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Directed codes: alternating pattern, all-zero and all-one comparators.
    launch(8'hA5); drain(200);
    launch(8'h00); drain(200);
    launch(8'hFF); drain(200);
    for (int i = 0; i < 3; i++) begin
      rc = NB'($urandom_range(0, 255));
      launch(rc); drain(200);
    end

    // START held high for 200 cycles: conversions every PER cycles.
    t0    = cyc;
    code  = 8'h3C;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h3C);
      exp_t_q.push_back(t0 + LAT + i * PER);
    end
    repeat (200) @(posedge clk);
    #1 start = 1'b0;
    drain(300);

    // Reset during SETTLE of bit 4 (its strobe would be at t+23).
    t0 = cyc;
    launch(8'h5A);
    repeat (20) @(posedge clk);
    #1;
    check_eq("pre_reset_cycle", cyc, t0 + 21);
    check_eq("pre_reset_strobes", sidx, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    launch(8'hC3); drain(200);

    // Small configuration with a 2-cycle dead time.
    launch4(4'h9); drain(100);
    launch4(4'h6); drain(100);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
